axi_master_wr_engine: RTL and testbench

Parametrised AXI4 master write engine; successor to the fixed-width write-control path of the AXI master. Accepts write commands and a data beat stream from the decoder. Drives the AW, W and B channels with up to MAX_OUTSTANDING bursts in flight. Checks each command against AXI4 legality rules before issue and returns per-burst responses to the decoder.

---
 rtl/axi_master_wr_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_master_wr_engine.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_wr_engine.sv
// AXI4 write master: legality-checks commands, issues AW, streams W beats, returns B responses.
// Latency: cmd accept -> AWVALID/cmd_err next cycle; B handshake -> rsp_valid next cycle; W is pass-through.
// Backpressure: cmd_ready low while AW pending, MAX_OUTSTANDING in flight or length queue full; W follows WREADY.
module axi_master_wr_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int STRB_W         = DATA_WIDTH / 8,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  AClk,
  input  logic                  ARst,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  cmd_err,
  // write data port
  input  logic [DATA_WIDTH-1:0] wdata_d,
  input  logic [STRB_W-1:0]     wstrb_d,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  // response port
  output logic                  rsp_valid,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_unexp,
  output logic [OUT_W-1:0]      outstanding,
  // AXI AW
  output logic [ID_WIDTH-1:0]   AWID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // AXI W
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_W-1:0]     WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // AXI B
  input  logic [ID_WIDTH-1:0]   BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       SIZE_MAX = 3'($clog2(STRB_W));
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AW channel registers
  logic                  r_awvalid;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic [2:0]            r_awsize;
  logic [1:0]            r_awburst;
  logic                  r_cmd_err;

  // length queue: one entry per issued burst, consumed by the W engine
  logic [7:0]            r_q_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_q_wr;
  logic [PTR_W-1:0]      r_q_rd;
  logic [OUT_W-1:0]      r_q_cnt;
  logic [7:0]            r_beat;

  // B path state
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_bready;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_unexp;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_issue;
  logic [19:0]           w_incr_bytes;
  logic [19:0]           w_incr_end;
  logic [ADDR_WIDTH-1:0] w_align_mask;
  logic                  w_q_empty;
  logic                  w_q_full;
  logic [7:0]            w_head_len;
  logic                  w_wlast;
  logic                  w_w_hs;
  logic                  w_pop;
  logic                  w_b_hs;
  logic                  w_b_dec;

  assign w_q_empty   = (r_q_cnt == '0);
  assign w_q_full    = (r_q_cnt == OUT_MAX);
  // held low during reset so the port reads idle while ARst is high
  assign w_cmd_ready = !ARst && !r_awvalid && (r_outstanding < OUT_MAX) && !w_q_full;
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_issue     = w_accept && !w_illegal;

  // AXI4 legality rules; wide arithmetic so the 4 KB check never wraps
  always_comb begin
    w_incr_bytes = (20'(cmd_len) + 20'd1) << cmd_size;
    w_incr_end   = 20'(cmd_addr[11:0]) + w_incr_bytes;
    w_align_mask = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
    w_illegal    = 1'b0;
    if (cmd_size > SIZE_MAX)
      w_illegal = 1'b1;
    if (cmd_burst == 2'b11)
      w_illegal = 1'b1;
    if (cmd_burst == BURST_WRAP && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      w_illegal = 1'b1;
    if (cmd_burst == BURST_WRAP && ((cmd_addr & w_align_mask) != '0))
      w_illegal = 1'b1;
    if (cmd_burst == BURST_INCR && (w_incr_end > 20'd4096))
      w_illegal = 1'b1;
    if (cmd_burst == BURST_FIXED && (cmd_len > 8'd15))
      w_illegal = 1'b1;
  end

  // AW payload loads on a legal accept and is held until the slave takes it
  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) begin
      r_awvalid <= 1'b0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_accept && w_illegal;
      if (w_issue) begin
        r_awvalid <= 1'b1;
        r_awid    <= cmd_id;
        r_awaddr  <= cmd_addr;
        r_awlen   <= cmd_len;
        r_awsize  <= cmd_size;
        r_awburst <= cmd_burst;
      end else if (r_awvalid && AWREADY) begin
        r_awvalid <= 1'b0;
      end
    end
  end

  // W engine: beats gated by a queued length so data never leads its command
  assign w_head_len  = r_q_mem[r_q_rd];
  assign w_wlast     = !w_q_empty && (r_beat == w_head_len);
  assign WVALID      = wdata_valid && !w_q_empty;
  assign wdata_ready = WREADY && !w_q_empty;
  assign w_w_hs      = WVALID && WREADY;
  assign w_pop       = w_w_hs && w_wlast;

  // length queue and beat counter; push and pop in one cycle leave the count unchanged
  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        r_q_mem[i] <= 8'd0;
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
      r_beat  <= 8'd0;
    end else begin
      if (w_issue) begin
        r_q_mem[r_q_wr] <= cmd_len;
        r_q_wr          <= r_q_wr + PTR_W'(1);
      end
      if (w_pop)
        r_q_rd <= r_q_rd + PTR_W'(1);
      if (w_issue && !w_pop)
        r_q_cnt <= r_q_cnt + OUT_W'(1);
      else if (!w_issue && w_pop)
        r_q_cnt <= r_q_cnt - OUT_W'(1);
      if (w_pop)
        r_beat <= 8'd0;
      else if (w_w_hs)
        r_beat <= r_beat + 8'd1;
    end
  end

  assign w_b_hs  = BVALID && r_bready;
  assign w_b_dec = w_b_hs && (r_outstanding != '0);

  // B path: register responses, track bursts in flight, flag responses with nothing pending
  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) begin
      r_bready      <= 1'b0;
      r_outstanding <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_resp    <= '0;
      r_rsp_unexp   <= 1'b0;
    end else begin
      r_bready    <= 1'b1;
      r_rsp_valid <= w_b_hs;
      r_rsp_unexp <= w_b_hs && (r_outstanding == '0);
      if (w_b_hs) begin
        r_rsp_id   <= BID;
        r_rsp_resp <= BRESP;
      end
      if (w_issue && !w_b_dec)
        r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_issue && w_b_dec)
        r_outstanding <= r_outstanding - OUT_W'(1);
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign cmd_err     = r_cmd_err;
  assign AWVALID     = r_awvalid;
  assign AWID        = r_awid;
  assign AWADDR      = r_awaddr;
  assign AWLEN       = r_awlen;
  assign AWSIZE      = r_awsize;
  assign AWBURST     = r_awburst;
  assign WDATA       = wdata_d;
  assign WSTRB       = wstrb_d;
  assign WLAST       = w_wlast;
  assign BREADY      = r_bready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_unexp   = r_rsp_unexp;
  assign outstanding = r_outstanding;

endmodule

// File: tb/tb_axi_master_wr_engine.sv
// Bench for axi_master_wr_engine: directed commands with scoreboards on AW, W and response ports.
// Stimulus drives at posedge+1; monitors sample at negedge.
// Ready/valid stalls come from a dedicated driver process.
module tb_axi_master_wr_engine;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int MO = 4;
  localparam int SW = DW / 8;
  localparam int OW = $clog2(MO) + 1;

  logic          AClk = 1'b0;
  logic          ARst;
  logic          cmd_valid, cmd_ready, cmd_err;
  logic [IW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic [DW-1:0] wdata_d;
  logic [SW-1:0] wstrb_d;
  logic          wdata_valid, wdata_ready;
  logic          rsp_valid, rsp_unexp;
  logic [IW-1:0] rsp_id;
  logic [1:0]    rsp_resp;
  logic [OW-1:0] outstanding;
  logic [IW-1:0] AWID;
  logic [AW-1:0] AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID, AWREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          WLAST, WVALID, WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY;

  axi_master_wr_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
    .AClk(AClk), .ARst(ARst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_err(cmd_err),
    .wdata_d(wdata_d), .wstrb_d(wstrb_d), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp), .rsp_unexp(rsp_unexp),
    .outstanding(outstanding),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 AClk = ~AClk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } aw_t;
  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [IW-1:0] id;
  } wb_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          unexp;
  } b_t;

  aw_t exp_aw[$];
  wb_t src_q[$];
  wb_t exp_w[$];
  b_t  b_req[$];
  b_t  exp_rsp[$];

  int checks = 0;
  int errors = 0;
  int w_hs_total = 0;
  int wlast_cnt = 0;
  int err_pulses = 0;
  int exp_err_cnt = 0;
  logic stall_en = 1'b0;
  logic auto_b = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=event expected=none", name);
  endtask

  function automatic b_t mk_b(input logic [IW-1:0] id, input logic [1:0] resp, input logic unexp);
    b_t b;
    b.id = id; b.resp = resp; b.unexp = unexp;
    return b;
  endfunction

  function automatic logic [63:0] pack_aw(input aw_t a);
    return 64'({a.id, a.addr, a.len, a.size, a.burst});
  endfunction

  // ready driver: fixed high or random stalls
  initial begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    forever begin
      @(posedge AClk); #1;
      if (stall_en) begin
        AWREADY = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        WREADY  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end else begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
      end
    end
  end

  // write data source: offers queued beats, advances on a sampled handshake
  initial begin
    logic hs;
    wdata_valid = 1'b0;
    wdata_d     = '0;
    wstrb_d     = '0;
    forever begin
      @(negedge AClk);
      hs = !ARst && wdata_valid && wdata_ready;
      @(posedge AClk); #1;
      if (hs && src_q.size() > 0)
        void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        wdata_valid = 1'b1;
        wdata_d     = src_q[0].data;
        wstrb_d     = src_q[0].strb;
      end else begin
        wdata_valid = 1'b0;
      end
    end
  end

  // B driver: one-cycle BVALID per request, expected response pushed when driven
  initial begin
    b_t e;
    BVALID = 1'b0;
    BID    = '0;
    BRESP  = '0;
    forever begin
      @(posedge AClk); #1;
      if (ARst || BVALID) begin
        BVALID = 1'b0;
      end else if (b_req.size() > 0) begin
        e = b_req.pop_front();
        BVALID = 1'b1;
        BID    = e.id;
        BRESP  = e.resp;
        exp_rsp.push_back(e);
      end
    end
  end

  // AW monitor: payload stability while stalled, payload scoreboard on handshake
  initial begin
    logic stalled;
    aw_t held, e;
    stalled = 1'b0;
    forever begin
      @(negedge AClk);
      if (ARst || !AWVALID) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk("aw_stable", 64'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST}), pack_aw(held));
        held.id = AWID; held.addr = AWADDR; held.len = AWLEN; held.size = AWSIZE; held.burst = AWBURST;
        if (AWREADY) begin
          stalled = 1'b0;
          if (exp_aw.size() == 0) fail("aw_extra");
          else begin
            e = exp_aw.pop_front();
            chk("aw_payload", 64'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST}), pack_aw(e));
          end
        end else begin
          stalled = 1'b1;
        end
      end
    end
  end

  // W monitor: beat scoreboard, WLAST counting, auto B generation
  initial begin
    wb_t e;
    forever begin
      @(negedge AClk);
      if (!ARst && WVALID && WREADY) begin
        w_hs_total++;
        if (WLAST) wlast_cnt++;
        if (exp_w.size() == 0) fail("w_extra_beat");
        else begin
          e = exp_w.pop_front();
          chk("wdata", 64'(WDATA), 64'(e.data));
          chk("wstrb", 64'(WSTRB), 64'(e.strb));
          chk("wlast", 64'(WLAST), 64'(e.last));
          if (e.last && auto_b) b_req.push_back(mk_b(e.id, 2'b00, 1'b0));
        end
      end
    end
  end

  // response monitor and cmd_err pulse counter
  initial begin
    b_t e;
    forever begin
      @(negedge AClk);
      if (!ARst && cmd_err) err_pulses++;
      if (!ARst && rsp_valid) begin
        if (exp_rsp.size() == 0) fail("rsp_extra");
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_unexp", 64'(rsp_unexp), 64'(e.unexp));
        end
      end
    end
  end

  task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input logic bad);
    int  t;
    wb_t w;
    aw_t a;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge AClk);
      t++;
    end while (!cmd_ready && t < 1000);
    if (!cmd_ready) begin
      fail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    if (bad) exp_err_cnt++;
    else begin
      a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
      exp_aw.push_back(a);
    end
    @(posedge AClk); #1;
    cmd_valid = 1'b0;
    if (bad) begin
      chk("cmd_err_pulse", 64'(cmd_err), 64'd1);
      chk("illegal_no_aw", 64'(AWVALID), 64'd0);
    end else begin
      chk("aw_latency", 64'(AWVALID), 64'd1);
      chk("legal_no_err", 64'(cmd_err), 64'd0);
      for (int b = 0; b <= int'(len); b++) begin
        w.data = (64'(id) << 48) | (64'(addr) << 16) | 64'(b);
        w.strb = SW'((64'd1 << (1 << size)) - 64'd1);
        w.last = (b == int'(len));
        w.id   = id;
        src_q.push_back(w);
        exp_w.push_back(w);
      end
    end
  endtask

  task automatic wait_w(input string name, input int limit);
    int t;
    t = 0;
    while (exp_w.size() != 0 && t < limit) begin
      @(posedge AClk); #2;
      t++;
    end
    if (t >= limit) fail(name);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int t;
    t = 0;
    while ((exp_w.size() != 0 || exp_aw.size() != 0 || src_q.size() != 0 || b_req.size() != 0 ||
            exp_rsp.size() != 0 || BVALID) && t < limit) begin
      @(posedge AClk); #2;
      t++;
    end
    if (t >= limit) fail(name);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, 64'(AWVALID), 64'd0);
    chk({tag, "_wvalid"}, 64'(WVALID), 64'd0);
    chk({tag, "_wlast"}, 64'(WLAST), 64'd0);
    chk({tag, "_wdata_ready"}, 64'(wdata_ready), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_bready"}, 64'(BREADY), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_cmd_err"}, 64'(cmd_err), 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // directed sequence
  initial begin
    logic [7:0] lens [8];
    int base, t;
    lens[0] = 8'd0; lens[1] = 8'd15; lens[2] = 8'd3; lens[3] = 8'd7;
    lens[4] = 8'd1; lens[5] = 8'd12; lens[6] = 8'd5; lens[7] = 8'd9;
    ARst = 1'b1;
    cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    #3;
    chk_idle_outputs("reset");
    repeat (2) @(posedge AClk);
    @(negedge AClk); ARst = 1'b0;
    @(posedge AClk); #1;
    chk("bready_after_reset", 64'(BREADY), 64'd1);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);

    // single INCR burst, 4 beats
    issue(4'd3, 32'h1000, 8'd3, 3'd3, 2'b01, 1'b0);
    chk("out_after_issue", 64'(outstanding), 64'd1);
    wait_w("t1_w_timeout", 200);
    b_req.push_back(mk_b(4'd3, 2'd0, 1'b0));
    wait_idle("t1_idle_timeout", 200);
    chk("t1_out_zero", 64'(outstanding), 64'd0);

    // 4 KB boundary: 0xFF8+16 crosses, 0xFF0+16 ends exactly on it
    issue(4'd1, 32'h0000_0FF8, 8'd1, 3'd3, 2'b01, 1'b1);
    chk("t2_out_unchanged", 64'(outstanding), 64'd0);
    @(posedge AClk); #1;
    chk("t2_no_awvalid", 64'(AWVALID), 64'd0);
    issue(4'd2, 32'h0000_0FF0, 8'd1, 3'd3, 2'b01, 1'b0);
    wait_w("t2_w_timeout", 200);
    b_req.push_back(mk_b(4'd2, 2'd1, 1'b0));
    wait_idle("t2_idle_timeout", 200);

    // WRAP legality, reserved burst, oversize beat, FIXED length
    issue(4'd4, 32'h100, 8'd2, 3'd2, 2'b10, 1'b1);
    issue(4'd4, 32'h102, 8'd3, 3'd2, 2'b10, 1'b1);
    issue(4'd5, 32'h104, 8'd3, 3'd2, 2'b10, 1'b0);
    wait_w("t3_w_timeout", 200);
    b_req.push_back(mk_b(4'd5, 2'd0, 1'b0));
    wait_idle("t3_idle_timeout", 200);
    issue(4'd6, 32'h0, 8'd0, 3'd3, 2'b11, 1'b1);
    issue(4'd6, 32'h0, 8'd0, 3'd4, 2'b01, 1'b1);
    issue(4'd7, 32'h200, 8'd16, 3'd2, 2'b00, 1'b1);
    issue(4'd7, 32'h200, 8'd15, 3'd2, 2'b00, 1'b0);
    wait_w("t3b_w_timeout", 200);
    b_req.push_back(mk_b(4'd7, 2'd0, 1'b0));
    wait_idle("t3b_idle_timeout", 200);
    chk("t3_out_zero", 64'(outstanding), 64'd0);
    chk("err_pulse_count", 64'(err_pulses), 64'(exp_err_cnt));

    // fill to MAX_OUTSTANDING with no B, then release one
    for (int i = 0; i < 4; i++)
      issue(IW'(i), 32'h5000 + 32'(i * 64), 8'd0, 3'd3, 2'b01, 1'b0);
    wait_w("t4_w_timeout", 200);
    @(posedge AClk); #1;
    chk("full_outstanding", 64'(outstanding), 64'd4);
    chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    b_req.push_back(mk_b(4'd2, 2'd2, 1'b0));
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge AClk); #2;
      t++;
    end
    if (!rsp_valid) fail("t4_rsp_timeout");
    chk("full_release_ready", 64'(cmd_ready), 64'd1);
    chk("full_release_out", 64'(outstanding), 64'd3);
    b_req.push_back(mk_b(4'd0, 2'd0, 1'b0));
    b_req.push_back(mk_b(4'd1, 2'd1, 1'b0));
    b_req.push_back(mk_b(4'd3, 2'd0, 1'b0));
    wait_idle("t4_idle_timeout", 200);
    chk("t4_out_zero", 64'(outstanding), 64'd0);

    // B with nothing outstanding
    b_req.push_back(mk_b(4'd9, 2'd3, 1'b1));
    wait_idle("unexp_timeout", 100);
    chk("unexp_out_zero", 64'(outstanding), 64'd0);

    // 8 bursts with random AWREADY/WREADY stalls and automatic B
    stall_en = 1'b1;
    auto_b   = 1'b1;
    base = wlast_cnt;
    for (int i = 0; i < 8; i++)
      issue(IW'(i), 32'h2000 + 32'(i * 256), lens[i], 3'd3, 2'b01, 1'b0);
    wait_idle("t5_idle_timeout", 5000);
    stall_en = 1'b0;
    auto_b   = 1'b0;
    chk("t5_wlast_count", 64'(wlast_cnt - base), 64'd8);
    chk("t5_out_zero", 64'(outstanding), 64'd0);

    // reset in the middle of an 8-beat burst
    repeat (2) @(posedge AClk);
    #1;
    base = w_hs_total;
    issue(4'd5, 32'h3000, 8'd7, 3'd3, 2'b01, 1'b0);
    t = 0;
    while (w_hs_total < base + 2 && t < 100) begin
      @(posedge AClk); #2;
      t++;
    end
    if (t >= 100) fail("t6_beat_timeout");
    ARst = 1'b1;
    src_q.delete();
    exp_w.delete();
    exp_aw.delete();
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(posedge AClk);
    @(negedge AClk); ARst = 1'b0;
    @(posedge AClk); #1;
    chk("t6_bready", 64'(BREADY), 64'd1);
    chk("t6_out_zero", 64'(outstanding), 64'd0);
    base = wlast_cnt;
    issue(4'd6, 32'h4000, 8'd0, 3'd3, 2'b01, 1'b0);
    wait_w("t6_w_timeout", 100);
    chk("t6_single_wlast", 64'(wlast_cnt - base), 64'd1);
    b_req.push_back(mk_b(4'd6, 2'd0, 1'b0));
    wait_idle("t6_idle_timeout", 100);
    chk("t6_final_out", 64'(outstanding), 64'd0);

    repeat (5) @(posedge AClk);
    #2;
    chk("end_aw_queue", 64'(exp_aw.size()), 64'd0);
    chk("end_w_queue", 64'(exp_w.size()), 64'd0);
    chk("end_rsp_queue", 64'(exp_rsp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
